// File: rtl/alu_add_pipe.sv
// Two-stage pipelined 32-bit add/subtract built around an external 8-slice carry-lookahead unit.
// Optional saturation on signed overflow is enabled with `define ALU_ADD_PIPE_SAT_EN (adds port IN_SAT).
module alu_add_pipe #(
    parameter int TAG_WIDTH = 4
) (
    input  logic                 CLK,
    input  logic                 N_RST,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [1:0]           IN_OP,
    input  logic [31:0]          IN_A,
    input  logic [31:0]          IN_B,
    input  logic                 IN_CF,
    input  logic [TAG_WIDTH-1:0] IN_TAG,
`ifdef ALU_ADD_PIPE_SAT_EN
    input  logic                 IN_SAT,
`endif
    output logic                 LA_C_IN,
    output logic [7:0]           LA_P,
    output logic [7:0]           LA_G,
    input  logic [7:0]           LA_CARRYS,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [31:0]          OUT_RESULT,
    output logic [3:0]           OUT_FLAGS,
    output logic [TAG_WIDTH-1:0] OUT_TAG
);

    logic [31:0]          b_eff;
    logic                 cin_d;
    logic [31:0]          s0n_d, s1n_d;
    logic [7:0]           p_d, g_d;

    logic                 s1v_q, s1v_d;
    logic [31:0]          s0n_q, s1n_q;
    logic [7:0]           p_q, g_q;
    logic                 cin_q, a31_q, b31_q;
    logic [TAG_WIDTH-1:0] tag1_q;
    logic                 sat_q;

    logic                 out_valid_q, out_valid_d;
    logic [31:0]          res_q, res_d, raw_res;
    logic [3:0]           flags_q, flags_d;
    logic [TAG_WIDTH-1:0] tag_q;
    logic [7:0]           slice_cin;
    logic                 ovf;

    logic                 in_fire, s2_load;

    assign s2_load  = s1v_q && (!out_valid_q || OUT_READY);
    assign IN_READY = !s1v_q || !out_valid_q || OUT_READY;
    assign in_fire  = IN_VALID && IN_READY;

    // Stage 1: operand prep and per-slice speculative sums
    assign b_eff = IN_OP[0] ? ~IN_B : IN_B;
    assign cin_d = IN_OP[1] ? IN_CF : IN_OP[0];

    for (genvar i = 0; i < 8; i++) begin : g_slice
        logic [4:0] sum0, sum1;
        assign sum0 = {1'b0, IN_A[4*i +: 4]} + {1'b0, b_eff[4*i +: 4]};
        assign sum1 = sum0 + 5'd1;
        assign s0n_d[4*i +: 4] = sum0[3:0];
        assign s1n_d[4*i +: 4] = sum1[3:0];
        assign g_d[i] = sum0[4];
        assign p_d[i] = sum1[4];
    end

    always_comb begin
        s1v_d = s1v_q;
        if (in_fire)
            s1v_d = 1'b1;
        else if (s2_load)
            s1v_d = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (in_fire) begin
            s0n_q  <= s0n_d;
            s1n_q  <= s1n_d;
            p_q    <= p_d;
            g_q    <= g_d;
            cin_q  <= cin_d;
            a31_q  <= IN_A[31];
            b31_q  <= b_eff[31];
            tag1_q <= IN_TAG;
`ifdef ALU_ADD_PIPE_SAT_EN
            sat_q  <= IN_SAT;
`else
            sat_q  <= 1'b0;
`endif
        end
    end

    // The lookahead unit sees only the held stage-1 state, never the live inputs
    assign LA_C_IN = cin_q;
    assign LA_P    = p_q;
    assign LA_G    = g_q;

    // Stage 2: carry-select per slice, flags, optional saturation
    assign slice_cin = {LA_CARRYS[6:0], cin_q};

    for (genvar i = 0; i < 8; i++) begin : g_sel
        assign raw_res[4*i +: 4] = slice_cin[i] ? s1n_q[4*i +: 4] : s0n_q[4*i +: 4];
    end

    assign ovf = (a31_q == b31_q) && (raw_res[31] != a31_q);

    always_comb begin
        res_d = raw_res;
        if (sat_q && ovf)
            res_d = a31_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
        flags_d = {res_d[31], (res_d == 32'd0), LA_CARRYS[7], ovf};
    end

    always_comb begin
        out_valid_d = out_valid_q;
        if (s2_load)
            out_valid_d = 1'b1;
        else if (OUT_READY)
            out_valid_d = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (!N_RST) begin
            s1v_q       <= 1'b0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            flags_q     <= '0;
            tag_q       <= '0;
        end else begin
            s1v_q       <= s1v_d;
            out_valid_q <= out_valid_d;
            if (s2_load) begin
                res_q   <= res_d;
                flags_q <= flags_d;
                tag_q   <= tag1_q;
            end
        end
    end

    assign OUT_VALID  = out_valid_q;
    assign OUT_RESULT = res_q;
    assign OUT_FLAGS  = flags_q;
    assign OUT_TAG    = tag_q;

endmodule

// File: tb/tb_alu_add_pipe.sv
// Scoreboard bench for alu_add_pipe with a behavioural carry-lookahead unit on the LA_* ports.
module tb_alu_add_pipe;

    localparam int TW = 4;

    logic          CLK = 1'b0;
    logic          N_RST;
    logic          IN_VALID;
    logic          IN_READY;
    logic [1:0]    IN_OP;
    logic [31:0]   IN_A, IN_B;
    logic          IN_CF;
    logic [TW-1:0] IN_TAG;
`ifdef ALU_ADD_PIPE_SAT_EN
    logic          IN_SAT;
`endif
    logic          LA_C_IN;
    logic [7:0]    LA_P, LA_G, LA_CARRYS;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [31:0]   OUT_RESULT;
    logic [3:0]    OUT_FLAGS;
    logic [TW-1:0] OUT_TAG;

    always #5 CLK = ~CLK;

    alu_add_pipe #(.TAG_WIDTH(TW)) dut (
        .CLK(CLK), .N_RST(N_RST),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_OP(IN_OP),
        .IN_A(IN_A), .IN_B(IN_B), .IN_CF(IN_CF), .IN_TAG(IN_TAG),
`ifdef ALU_ADD_PIPE_SAT_EN
        .IN_SAT(IN_SAT),
`endif
        .LA_C_IN(LA_C_IN), .LA_P(LA_P), .LA_G(LA_G), .LA_CARRYS(LA_CARRYS),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_RESULT(OUT_RESULT),
        .OUT_FLAGS(OUT_FLAGS), .OUT_TAG(OUT_TAG)
    );

    // Behavioural lookahead unit: ripple of generate/propagate from the carry-in
    function automatic logic [7:0] la_model(input logic [7:0] p, input logic [7:0] g, input logic ci);
        logic [7:0] co;
        logic c;
        c = ci;
        for (int i = 0; i < 8; i++) begin
            co[i] = g[i] | (p[i] & c);
            c = co[i];
        end
        return co;
    endfunction

    assign LA_CARRYS = la_model(LA_P, LA_G, LA_C_IN);

    typedef struct {
        logic [31:0]   res;
        logic [3:0]    fl;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t          sb[$];
    int            n_vec = 0;
    int            n_miss = 0;
    logic [TW-1:0] tag_ctr = '0;

    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ADC = 2'b10, SBC = 2'b11;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op; the expected result is queued on the edge that accepts it
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic cf, input logic sat, input logic [31:0] er, input logic [3:0] ef);
        int waits;
        waits = 0;
        IN_VALID = 1'b1; IN_OP = op; IN_A = a; IN_B = b; IN_CF = cf; IN_TAG = tag_ctr;
`ifdef ALU_ADD_PIPE_SAT_EN
        IN_SAT = sat;
`else
        if (sat) $display("note: saturation request ignored in this build");
`endif
        forever begin
            @(negedge CLK);
            if (IN_READY) break;
            waits++;
            if (waits > 50) begin
                n_vec++; n_miss++;
                $display("FAIL accept_timeout: got IN_READY=0 for %0d cycles expected 1", waits);
                IN_VALID = 1'b0;
                return;
            end
        end
        @(posedge CLK);
        sb.push_back('{er, ef, tag_ctr});
        tag_ctr = tag_ctr + 1'b1;
        #1 IN_VALID = 1'b0;
    endtask

    task automatic wait_empty();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(negedge CLK);
            k++;
        end
        chk("drain_remaining", sb.size(), 0);
        repeat (2) @(posedge CLK);
        #1;
    endtask

    // Monitor: pops on every output transfer and checks outputs hold while stalled
    logic          hold = 1'b0;
    logic [31:0]   h_res;
    logic [3:0]    h_fl;
    logic [TW-1:0] h_tag;

    always @(negedge CLK) begin
        if (!N_RST) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("stall_valid", OUT_VALID, 1);
                chk("stall_result", OUT_RESULT, h_res);
                chk("stall_flags", OUT_FLAGS, h_fl);
                chk("stall_tag", OUT_TAG, h_tag);
            end
            if (OUT_VALID && OUT_READY) begin
                if (sb.size() == 0) begin
                    n_vec++; n_miss++;
                    $display("FAIL unexpected_out: got result %h with empty queue expected none", OUT_RESULT);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", OUT_RESULT, e.res);
                    chk("flags", OUT_FLAGS, e.fl);
                    chk("tag", OUT_TAG, e.tag);
                end
            end
            hold  = OUT_VALID && !OUT_READY;
            h_res = OUT_RESULT;
            h_fl  = OUT_FLAGS;
            h_tag = OUT_TAG;
        end
    end

    initial begin
        N_RST = 1'b0; OUT_READY = 1'b1; IN_VALID = 1'b0;
        IN_OP = ADD; IN_A = '0; IN_B = '0; IN_CF = 1'b0; IN_TAG = '0;
`ifdef ALU_ADD_PIPE_SAT_EN
        IN_SAT = 1'b0;
`endif
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_in_ready", IN_READY, 1);
        chk("rst_result", OUT_RESULT, 0);
        chk("rst_flags", OUT_FLAGS, 0);
        chk("rst_tag", OUT_TAG, 0);
        N_RST = 1'b1;
        @(posedge CLK);
        #1;

        // Directed vectors; flags are {N,Z,C,V}
        send(ADD, 32'h0000_000F, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0010, 4'b0000);
        chk("la_p", LA_P, 8'h01);
        chk("la_g", LA_G, 8'h01);
        chk("la_cin", LA_C_IN, 0);
        send(SUB, 32'd5, 32'd5, 1'b0, 1'b0, 32'h0000_0000, 4'b0110);
        send(ADD, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 4'b1001);
`ifdef ALU_ADD_PIPE_SAT_EN
        send(ADD, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 4'b0001);
        send(SUB, 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h8000_0000, 4'b1011);
`endif
        send(ADC, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 32'h0000_0000, 4'b0110);
        send(SBC, 32'd0, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 4'b1000);
        send(SUB, 32'h8000_0000, 32'd1, 1'b0, 1'b0, 32'h7FFF_FFFF, 4'b0011);
        wait_empty();

        // Stream four ops and stall the output for three cycles at the first result
        fork
            begin
                send(ADD, 32'd1, 32'd2, 1'b0, 1'b0, 32'd3, 4'b0000);
                send(ADD, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 4'b0000);
                send(SUB, 32'd3, 32'd5, 1'b0, 1'b0, 32'hFFFF_FFFE, 4'b1000);
                send(ADD, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h0000_0000, 4'b0110);
            end
            begin
                int k;
                k = 0;
                do begin
                    @(posedge CLK);
                    #1;
                    k++;
                end while (!OUT_VALID && k < 20);
                chk("stream_first_valid", OUT_VALID, 1);
                OUT_READY = 1'b0;
                @(negedge CLK);
                chk("stall_in_ready", IN_READY, 0);
                repeat (3) @(posedge CLK);
                #1 OUT_READY = 1'b1;
            end
        join
        wait_empty();

        // Reset with both stages full
        OUT_READY = 1'b0;
        send(ADD, 32'd10, 32'd20, 1'b0, 1'b0, 32'd30, 4'b0000);
        send(ADD, 32'd40, 32'd50, 1'b0, 1'b0, 32'd90, 4'b0000);
        @(negedge CLK);
        chk("full_in_ready", IN_READY, 0);
        chk("full_out_valid", OUT_VALID, 1);
        @(posedge CLK);
        #1 N_RST = 1'b0;
        sb.delete();
        @(posedge CLK);
        #1;
        chk("rst2_out_valid", OUT_VALID, 0);
        chk("rst2_result", OUT_RESULT, 0);
        chk("rst2_in_ready", IN_READY, 1);
        N_RST = 1'b1;
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        send(ADD, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h0000_0000, 4'b0110);
        @(negedge CLK);
        chk("lat_cycle1_valid", OUT_VALID, 0);
        @(negedge CLK);
        chk("lat_cycle2_valid", OUT_VALID, 1);
        wait_empty();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
